fir_frame_sequencer: RTL and testbench

- Sequences one frame of samples through the FIR core, which has a single-sample `inputValid`/`outputValid` handshake.
- Takes samples from an upstream valid/ready stream, hands each to the core with a one-cycle valid pulse and waits for the core's result.
- Presents each result on a downstream valid/ready stream and counts completed samples until the frame length is reached.
- Sits between the sample source (memory or FIFO) and the FIR core, replacing testbench-level feed sequencing in synthesizable form.

---
 rtl/fir_ctrl_pkg.sv | 22 ++
 rtl/fir_wdog.sv | 38 +++
 rtl/fir_frame_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_fir_frame_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
// Shared definitions for the FIR frame sequencer: the controller state
// encoding and the default widths and sizes used when the top is built
// without parameter overrides.
package fir_ctrl_pkg;

  localparam int IN_W        = 16;      // sample width
  localparam int OUT_W       = 38;      // FIR result width
  localparam int CNT_W       = 18;      // sample counter width
  localparam int FRAME_LEN   = 221184;  // samples per frame
  localparam int TIMEOUT_CYC = 256;     // watchdog limit in WAIT_OUT cycles

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_OUT,
    DELIVER,
    DONE
  } state_t;

endpackage

// File: rtl/fir_wdog.sv
// fir_wdog
// Loadable down-counter used as the WAIT_OUT watchdog. Loading places
// load_val in the counter; each enabled cycle counts down by one and the
// count parks at zero. expired is high whenever the count is zero.
//
// Ports:
//   clkk      in  1  clock, rising edge
//   rst_n     in  1  synchronous active-low reset (count clears to 0)
//   load      in  1  load load_val (takes priority over en)
//   load_val  in  W  value to load
//   en        in  1  count down by one
//   expired   out 1  count is zero
module fir_wdog #(
  parameter int W = 9
) (
  input  logic         clkk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clkk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/fir_frame_sequencer.sv
// fir_frame_sequencer
// Feeds one frame of samples through a FIR core that has a single-sample
// inputValid/outputValid handshake. Each upstream sample is captured,
// handed to the core with a one-cycle valid pulse, the core result is
// captured and offered downstream; the frame ends after FRAME_LEN results
// have been accepted downstream.
//
// Optional feature macro: FIR_TIMEOUT_EN
//   defined   - a watchdog aborts the frame (to DONE, still pulsing done)
//               when the core gives no result within TIMEOUT_CYC cycles
//               of WAIT_OUT, and sets the sticky err_timeout flag.
//   undefined - WAIT_OUT waits forever, err_timeout is tied to 0.
//
// Ports:
//   clkk          in  1      clock, rising edge
//   rst_n         in  1      synchronous active-low reset
//   start         in  1      begin a frame (honoured only in IDLE)
//   s_valid       in  1      upstream sample valid
//   s_ready       out 1      upstream ready (FETCH only)
//   s_data        in  IN_W   upstream sample
//   fir_in_valid  out 1      one-cycle pulse to core inputValid
//   fir_in_data   out IN_W   to core FIR_input (captured sample)
//   fir_out_valid in  1      core outputValid (used in WAIT_OUT only)
//   fir_out_data  in  OUT_W  core FIR_output
//   m_valid       out 1      downstream result valid (DELIVER)
//   m_ready       in  1      downstream ready
//   m_data        out OUT_W  downstream result (captured core output)
//   sample_cnt    out CNT_W  results delivered in the current frame
//   busy          out 1      any state except IDLE
//   done          out 1      one-cycle end-of-frame pulse
//   err_timeout   out 1      sticky watchdog error
module fir_frame_sequencer #(
  parameter int IN_W        = fir_ctrl_pkg::IN_W,
  parameter int OUT_W       = fir_ctrl_pkg::OUT_W,
  parameter int FRAME_LEN   = fir_ctrl_pkg::FRAME_LEN,
  parameter int CNT_W       = fir_ctrl_pkg::CNT_W,
  parameter int TIMEOUT_CYC = fir_ctrl_pkg::TIMEOUT_CYC
) (
  input  logic             clkk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             fir_in_valid,
  output logic [IN_W-1:0]  fir_in_data,
  input  logic             fir_out_valid,
  input  logic [OUT_W-1:0] fir_out_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             busy,
  output logic             done,
  output logic             err_timeout
);

  import fir_ctrl_pkg::*;

  // Elaboration-time sanity checks on the frame configuration.
  if (FRAME_LEN < 1) begin : g_bad_frame_len
    $error("FRAME_LEN must be at least 1");
  end
  if ((CNT_W < 32) && ((longint'(1) << CNT_W) <= longint'(FRAME_LEN))) begin : g_bad_cnt_w
    $error("CNT_W too narrow for FRAME_LEN");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // Count value at which the next accepted result completes the frame.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t             state_reg, state_next;
  logic [IN_W-1:0]    in_data_reg;
  logic [OUT_W-1:0]   out_data_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               timeout_hit;

  // State register
  always_ff @(posedge clkk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next   = state_reg;
    s_ready      = 1'b0;
    fir_in_valid = 1'b0;
    m_valid      = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = FETCH;
      end
      FETCH: begin
        s_ready = 1'b1;
        if (s_valid) state_next = ISSUE;
      end
      ISSUE: begin
        fir_in_valid = 1'b1;
        state_next   = WAIT_OUT;
      end
      WAIT_OUT: begin
        // A result arriving in the expiry cycle still wins.
        if (fir_out_valid)    state_next = DELIVER;
        else if (timeout_hit) state_next = DONE;
      end
      DELIVER: begin
        m_valid = 1'b1;
        if (m_ready) state_next = (cnt_reg == LAST_CNT) ? DONE : FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Data capture and result counter
  always_ff @(posedge clkk) begin
    if (!rst_n) begin
      in_data_reg  <= '0;
      out_data_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        cnt_reg <= '0;
      end
      if ((state_reg == FETCH) && s_valid) begin
        in_data_reg <= s_data;
      end
      if ((state_reg == WAIT_OUT) && fir_out_valid) begin
        out_data_reg <= fir_out_data;
      end
      if ((state_reg == DELIVER) && m_ready) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign fir_in_data = in_data_reg;
  assign m_data      = out_data_reg;
  assign sample_cnt  = cnt_reg;

`ifdef FIR_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

  logic wdog_expired;
  logic err_reg;

  // Loaded during ISSUE so the first WAIT_OUT cycle sees TIMEOUT_CYC-1;
  // the counter reaches zero in the TIMEOUT_CYC-th WAIT_OUT cycle.
  fir_wdog #(
    .W (WDOG_W)
  ) u_wdog (
    .clkk     (clkk),
    .rst_n    (rst_n),
    .load     (state_reg == ISSUE),
    .load_val (WDOG_W'(TIMEOUT_CYC - 1)),
    .en       (state_reg == WAIT_OUT),
    .expired  (wdog_expired)
  );

  assign timeout_hit = (state_reg == WAIT_OUT) && wdog_expired && !fir_out_valid;

  always_ff @(posedge clkk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if ((state_reg == IDLE) && start) begin
      err_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_reg <= 1'b1;
    end
  end

  assign err_timeout = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// tb_fir_frame_sequencer
// Bench for fir_frame_sequencer. Instance dut_a runs FRAME_LEN=4 and
// instance dut_b runs FRAME_LEN=1; both use TIMEOUT_CYC=16. Each has a
// behavioural FIR core that registers the input on the pulse and returns
// f(x) a programmable number of cycles after that.
// Build with +define+FIR_TIMEOUT_EN to exercise the watchdog.
module tb_fir_frame_sequencer;

  localparam int IN_W  = 16;
  localparam int OUT_W = 38;
  localparam int CNT_W = 18;

  int vectors     = 0;
  int miscompares = 0;

  logic clkk = 1'b0;
  always #5 clkk = ~clkk;

  // ---------------- DUT A (FRAME_LEN = 4) ----------------
  logic             rst_n_a, start_a, s_valid_a, s_ready_a, fir_in_valid_a;
  logic [IN_W-1:0]  s_data_a, fir_in_data_a;
  logic             fir_out_valid_a, m_valid_a, m_ready_a;
  logic [OUT_W-1:0] fir_out_data_a, m_data_a;
  logic [CNT_W-1:0] sample_cnt_a;
  logic             busy_a, done_a, err_timeout_a;

  fir_frame_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FRAME_LEN(4), .CNT_W(CNT_W), .TIMEOUT_CYC(16)
  ) dut_a (
    .clkk(clkk), .rst_n(rst_n_a), .start(start_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .fir_in_valid(fir_in_valid_a), .fir_in_data(fir_in_data_a),
    .fir_out_valid(fir_out_valid_a), .fir_out_data(fir_out_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .sample_cnt(sample_cnt_a), .busy(busy_a), .done(done_a),
    .err_timeout(err_timeout_a)
  );

  // ---------------- DUT B (FRAME_LEN = 1) ----------------
  logic             rst_n_b, start_b, s_valid_b, s_ready_b, fir_in_valid_b;
  logic [IN_W-1:0]  s_data_b, fir_in_data_b;
  logic             fir_out_valid_b, m_valid_b, m_ready_b;
  logic [OUT_W-1:0] fir_out_data_b, m_data_b;
  logic [CNT_W-1:0] sample_cnt_b;
  logic             busy_b, done_b, err_timeout_b;

  fir_frame_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FRAME_LEN(1), .CNT_W(CNT_W), .TIMEOUT_CYC(16)
  ) dut_b (
    .clkk(clkk), .rst_n(rst_n_b), .start(start_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .fir_in_valid(fir_in_valid_b), .fir_in_data(fir_in_data_b),
    .fir_out_valid(fir_out_valid_b), .fir_out_data(fir_out_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .sample_cnt(sample_cnt_b), .busy(busy_b), .done(done_b),
    .err_timeout(err_timeout_b)
  );

  // ---------------- behavioural FIR cores ----------------
  function automatic logic [OUT_W-1:0] core_fn(input logic [IN_W-1:0] x);
    return {6'h2A, ~x, x};
  endfunction

  int               lat_a = 3, cd_a = 0, lat_b = 2, cd_b = 0;
  bit               core_on_a = 1'b1, pend_a = 1'b0, pend_b = 1'b0;
  logic [OUT_W-1:0] pdata_a = '0, pdata_b = '0;
  logic             inj_a = 1'b0;
  logic [OUT_W-1:0] inj_data_a = '0;
  logic             real_v_a, real_v_b;

  // Core: registers the input on the pulse, result is valid lat cycles later.
  always @(posedge clkk) begin
    if (fir_in_valid_a && core_on_a) begin
      pend_a <= 1'b1; cd_a <= lat_a; pdata_a <= core_fn(fir_in_data_a);
    end else if (pend_a) begin
      if (cd_a == 0) pend_a <= 1'b0; else cd_a <= cd_a - 1;
    end
    if (fir_in_valid_b) begin
      pend_b <= 1'b1; cd_b <= lat_b; pdata_b <= core_fn(fir_in_data_b);
    end else if (pend_b) begin
      if (cd_b == 0) pend_b <= 1'b0; else cd_b <= cd_b - 1;
    end
  end

  assign real_v_a        = pend_a && (cd_a == 0);
  assign real_v_b        = pend_b && (cd_b == 0);
  assign fir_out_valid_a = real_v_a | inj_a;
  assign fir_out_data_a  = real_v_a ? pdata_a : inj_data_a;
  assign fir_out_valid_b = real_v_b;
  assign fir_out_data_b  = pdata_b;

  task automatic step();
    @(posedge clkk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors++;
    if ({s_ready_a, fir_in_valid_a, m_valid_a, busy_a, done_a, err_timeout_a} !== 6'b0 ||
        fir_in_data_a !== '0 || m_data_a !== '0 || sample_cnt_a !== '0) begin
      miscompares++;
      $display("FAIL reset_a: ctrl=%b in=%h out=%h cnt=%0d required all zero",
               {s_ready_a, fir_in_valid_a, m_valid_a, busy_a, done_a, err_timeout_a},
               fir_in_data_a, m_data_a, sample_cnt_a);
    end
    vectors++;
    if ({s_ready_b, fir_in_valid_b, m_valid_b, busy_b, done_b, err_timeout_b} !== 6'b0 ||
        fir_in_data_b !== '0 || m_data_b !== '0 || sample_cnt_b !== '0) begin
      miscompares++;
      $display("FAIL reset_b: ctrl=%b cnt=%0d required all zero",
               {s_ready_b, fir_in_valid_b, m_valid_b, busy_b, done_b, err_timeout_b}, sample_cnt_b);
    end
    // start while held in reset must not take effect
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start: busy=%b required 0", busy_a);
    end
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    step();
    $display("tb: reset checked");
  endtask

  // One FRAME_LEN=4 frame on dut_a, checked cycle by cycle against a
  // transaction-level model of the handshakes.
  task automatic test_frame(input string name, input int lat, input int sv_gap,
                            input int mr_gap, input bit inject, input bit fixed,
                            input bit hold10);
    logic [IN_W-1:0]  ins [4];
    logic [OUT_W-1:0] exp_res [4];
    logic [OUT_W-1:0] prev_md = '0;
    int  in_idx = 0, out_idx = 0, exp_cnt = 0, last_iss = -1, cycles = 0, hold_left;
    bit  exp_sready = 1, exp_fiv = 0, exp_mv = 0, exp_done = 0, exp_busy = 1;
    bit  post = 0, finished = 0, prev_mv = 0, prev_acc = 0, mhs, shs;
    lat_a     = lat;
    core_on_a = 1'b1;
    hold_left = hold10 ? 10 : 0;
    for (int i = 0; i < 4; i++) begin
      ins[i]     = fixed ? IN_W'(i + 1) : IN_W'($urandom);
      exp_res[i] = core_fn(ins[i]);
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    while (!finished && cycles < 400) begin
      vectors++;
      if ({s_ready_a, fir_in_valid_a, m_valid_a, done_a, busy_a, err_timeout_a} !==
          {exp_sready, exp_fiv, exp_mv, exp_done, exp_busy, 1'b0}) begin
        miscompares++;
        $display("FAIL %s ctrl cyc %0d: rdy/iss/mv/done/busy/err=%b required %b", name, cycles,
                 {s_ready_a, fir_in_valid_a, m_valid_a, done_a, busy_a, err_timeout_a},
                 {exp_sready, exp_fiv, exp_mv, exp_done, exp_busy, 1'b0});
      end
      vectors++;
      if (sample_cnt_a !== CNT_W'(exp_cnt)) begin
        miscompares++;
        $display("FAIL %s sample_cnt cyc %0d: got %0d required %0d", name, cycles, sample_cnt_a, exp_cnt);
      end
      if (in_idx > 0) begin
        vectors++;
        if (fir_in_data_a !== ins[in_idx-1]) begin
          miscompares++;
          $display("FAIL %s fir_in_data cyc %0d: got %h required %h", name, cycles, fir_in_data_a, ins[in_idx-1]);
        end
      end
      if (fir_in_valid_a) begin
        if (sv_gap == 0 && mr_gap == 0 && !hold10 && last_iss >= 0) begin
          vectors++;
          if (cycles - last_iss != 4 + lat) begin
            miscompares++;
            $display("FAIL %s period: got %0d cycles required %0d", name, cycles - last_iss, 4 + lat);
          end
        end
        last_iss = cycles;
      end
      if (prev_mv && !prev_acc) begin
        vectors++;
        if (m_valid_a !== 1'b1 || m_data_a !== prev_md) begin
          miscompares++;
          $display("FAIL %s hold cyc %0d: m_valid=%b m_data=%h required 1 and %h", name, cycles,
                   m_valid_a, m_data_a, prev_md);
        end
      end
      if (m_valid_a && out_idx < 4) begin
        vectors++;
        if (m_data_a !== exp_res[out_idx]) begin
          miscompares++;
          $display("FAIL %s m_data #%0d: got %h required %h", name, out_idx, m_data_a, exp_res[out_idx]);
        end
      end

      // drive inputs for the coming edge
      s_valid_a  = ($urandom_range(99) >= sv_gap);
      s_data_a   = (s_valid_a && in_idx < 4) ? ins[in_idx] : IN_W'($urandom);
      if (m_valid_a && out_idx == 1 && hold_left > 0) begin
        m_ready_a = 1'b0;
        hold_left--;
      end else begin
        m_ready_a = ($urandom_range(99) >= mr_gap);
      end
      inj_a      = inject && (s_ready_a || fir_in_valid_a) && ($urandom_range(1) == 1);
      inj_data_a = {6'h15, IN_W'($urandom), IN_W'($urandom)};

      // expectations for the next cycle
      mhs = m_valid_a && m_ready_a;
      shs = s_valid_a && s_ready_a;
      if (post) finished = 1'b1;
      if (exp_done) begin post = 1'b1; exp_busy = 1'b0; end
      exp_done = 1'b0;
      exp_fiv  = shs;
      if (shs) begin in_idx++; exp_sready = 1'b0; end
      if (real_v_a) exp_mv = 1'b1;
      if (mhs) begin
        $display("tb: %s sample %0d in=%h out=%h", name, out_idx, ins[out_idx], m_data_a);
        out_idx++;
        exp_cnt = out_idx;
        exp_mv  = 1'b0;
        if (out_idx == 4) exp_done = 1'b1; else exp_sready = 1'b1;
      end
      prev_mv  = m_valid_a;
      prev_acc = mhs;
      prev_md  = m_data_a;
      step();
      cycles++;
    end
    vectors++;
    if (!finished || out_idx != 4) begin
      miscompares++;
      $display("FAIL %s completion: finished=%0d delivered=%0d required 1 and 4", name, finished, out_idx);
    end
    s_valid_a = 1'b0; m_ready_a = 1'b0; inj_a = 1'b0;
  endtask

  // FRAME_LEN=1 on dut_b with L=2: ISSUE at 2, DELIVER at 6, DONE at 7, IDLE at 8.
  task automatic test_single();
    logic [IN_W-1:0] x;
    int iss_n = 0, del_n = 0, done_n = 0, iss_c = -1, del_c = -1, done_c = -1, busy_fall = -1;
    x = IN_W'($urandom);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    s_valid_b = 1'b1; s_data_b = x; m_ready_b = 1'b1;
    for (int c = 1; c < 20; c++) begin
      if (fir_in_valid_b) begin iss_n++; iss_c = c; end
      if (m_valid_b) begin
        del_n++; del_c = c;
        vectors++;
        if (m_data_b !== core_fn(x)) begin
          miscompares++;
          $display("FAIL single m_data: got %h required %h", m_data_b, core_fn(x));
        end
      end
      if (done_b) begin done_n++; done_c = c; end
      if (!busy_b && busy_fall < 0) busy_fall = c;
      if (c > 1) s_data_b = IN_W'($urandom);
      step();
    end
    s_valid_b = 1'b0; m_ready_b = 1'b0;
    vectors++;
    if (iss_n != 1 || del_n != 1 || done_n != 1) begin
      miscompares++;
      $display("FAIL single counts: issue=%0d deliver=%0d done=%0d required 1 1 1", iss_n, del_n, done_n);
    end
    vectors++;
    if (iss_c != 2 || del_c != 6 || done_c != 7 || busy_fall != 8) begin
      miscompares++;
      $display("FAIL single timing: issue@%0d deliver@%0d done@%0d idle@%0d required 2 6 7 8",
               iss_c, del_c, done_c, busy_fall);
    end
    vectors++;
    if (sample_cnt_b !== CNT_W'(1)) begin
      miscompares++;
      $display("FAIL single sample_cnt: got %0d required 1", sample_cnt_b);
    end
    $display("tb: single frame in=%h issue@%0d deliver@%0d done@%0d", x, iss_c, del_c, done_c);
  endtask

  // Reset in WAIT_OUT of sample 2; the core's late result must be ignored.
  task automatic test_reset_mid();
    int issues = 0, guard = 0;
    lat_a = 3; core_on_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    s_valid_a = 1'b1; m_ready_a = 1'b1;
    while (issues < 2 && guard < 100) begin
      s_data_a = IN_W'($urandom);
      if (fir_in_valid_a) issues++;
      if (issues < 2) begin step(); guard++; end
    end
    s_valid_a = 1'b0;
    step(); step();
    rst_n_a = 1'b0;
    step();
    rst_n_a = 1'b1;
    vectors++;
    if ({s_ready_a, fir_in_valid_a, m_valid_a, busy_a, done_a, err_timeout_a} !== 6'b0 ||
        fir_in_data_a !== '0 || m_data_a !== '0 || sample_cnt_a !== '0 || issues != 2) begin
      miscompares++;
      $display("FAIL reset_mid: ctrl=%b cnt=%0d issues=%0d required zero outputs after 2 issues",
               {s_ready_a, fir_in_valid_a, m_valid_a, busy_a, done_a, err_timeout_a}, sample_cnt_a, issues);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      vectors++;
      if (m_valid_a || done_a || busy_a || sample_cnt_a !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_idle cyc %0d: m_valid=%b done=%b busy=%b cnt=%0d required 0",
                 c, m_valid_a, done_a, busy_a, sample_cnt_a);
      end
    end
    $display("tb: reset during WAIT_OUT of sample 2 applied");
  endtask

  // Core never answers.
  task automatic test_timeout();
    core_on_a = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    s_valid_a = 1'b1; s_data_a = IN_W'($urandom);
    step();
    s_valid_a = 1'b0;
    vectors++;
    if (fir_in_valid_a !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_issue: fir_in_valid=%b required 1", fir_in_valid_a);
    end
`ifdef FIR_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      step();
      vectors++;
      if (err_timeout_a || done_a || !busy_a || m_valid_a) begin
        miscompares++;
        $display("FAIL timeout_wait %0d: err=%b done=%b busy=%b m_valid=%b required 0 0 1 0",
                 k, err_timeout_a, done_a, busy_a, m_valid_a);
      end
    end
    step();
    vectors++;
    if (err_timeout_a !== 1'b1 || done_a !== 1'b1 || sample_cnt_a !== '0) begin
      miscompares++;
      $display("FAIL timeout_fire: err=%b done=%b cnt=%0d required 1 1 0", err_timeout_a, done_a, sample_cnt_a);
    end
    step(); step(); step();
    vectors++;
    if (err_timeout_a !== 1'b1 || done_a || busy_a) begin
      miscompares++;
      $display("FAIL timeout_sticky: err=%b done=%b busy=%b required 1 0 0", err_timeout_a, done_a, busy_a);
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    vectors++;
    if (err_timeout_a !== 1'b0 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_clear: err=%b busy=%b required 0 1", err_timeout_a, busy_a);
    end
    $display("tb: watchdog fired after 16 WAIT_OUT cycles and cleared on start");
`else
    for (int k = 1; k <= 40; k++) begin
      step();
      vectors++;
      if (err_timeout_a || done_a || !busy_a || m_valid_a) begin
        miscompares++;
        $display("FAIL wait_forever %0d: err=%b done=%b busy=%b m_valid=%b required 0 0 1 0",
                 k, err_timeout_a, done_a, busy_a, m_valid_a);
      end
    end
    $display("tb: WAIT_OUT held 40 cycles without a core result");
`endif
    rst_n_a = 1'b0;
    step();
    rst_n_a = 1'b1;
    core_on_a = 1'b1;
    step();
  endtask

  initial begin
    rst_n_a = 1'b0; start_a = 1'b0; s_valid_a = 1'b0; s_data_a = '0; m_ready_a = 1'b0;
    rst_n_b = 1'b0; start_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0; m_ready_b = 1'b0;
    repeat (3) step();
    test_reset();
    test_frame("basic", 3, 0, 0, 1'b0, 1'b1, 1'b0);
    test_frame("rand_l1", 1, 0, 0, 1'b0, 1'b0, 1'b0);
    test_frame("rand_l5", 5, 0, 0, 1'b0, 1'b0, 1'b0);
    test_frame("gaps", $urandom_range(1, 4), 40, 40, 1'b0, 1'b0, 1'b0);
    test_frame("inject", 3, 0, 0, 1'b1, 1'b0, 1'b0);
    test_frame("hold10", 2, 0, 0, 1'b0, 1'b0, 1'b1);
    test_single();
    test_reset_mid();
    test_frame("after_reset", 3, 0, 0, 1'b0, 1'b0, 1'b0);
    test_timeout();
    test_frame("back_to_back", 2, 20, 20, 1'b1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
